// File: rtl/loop_count_ctrl_pkg.sv
// Shared types and constants for the loop count controller (package loop_pkg).
// Also holds the output decode helpers used by the controller's output registers.
package loop_pkg;

    localparam int   LOOP_WIDTH = 10;
    localparam logic SEL_INIT   = 1'b1;
    localparam logic SEL_CUR    = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Mux select wanted while sitting in a given state.
    function automatic logic sel_of(input state_t s);
        logic r;
        case (s)
            S_IDLE:  r = SEL_INIT;
            S_LOAD:  r = SEL_INIT;
            S_COUNT: r = SEL_CUR;
            S_DONE:  r = SEL_CUR;
            default: r = SEL_INIT;
        endcase
        return r;
    endfunction

    function automatic logic busy_of(input state_t s);
        return (s == S_LOAD) || (s == S_COUNT);
    endfunction

endpackage

// File: rtl/loop_count_ctrl_if.sv
// Handshake/data bundle between loop_count_ctrl and its environment (loop_mux, sequencer).
// LOOP_AUTO_RELOAD_EN adds the stop input and the wrap_cnt output.
interface loop_count_ctrl_if #(parameter int WIDTH = loop_pkg::LOOP_WIDTH);

    logic             start;
    logic             abort;
    logic             tick_en;
    logic [WIDTH-1:0] L;
    logic             sel;
    logic [WIDTH-1:0] current_count;
    logic             busy;
    logic             done;
`ifdef LOOP_AUTO_RELOAD_EN
    logic             stop;
    logic [7:0]       wrap_cnt;

    modport master (output start, abort, tick_en, L, stop,
                    input  sel, current_count, busy, done, wrap_cnt);
    modport slave  (input  start, abort, tick_en, L, stop,
                    output sel, current_count, busy, done, wrap_cnt);
`else
    modport master (output start, abort, tick_en, L,
                    input  sel, current_count, busy, done);
    modport slave  (input  start, abort, tick_en, L,
                    output sel, current_count, busy, done);
`endif

endinterface

// File: rtl/loop_count_ctrl.sv
// Loop count register plus IDLE/LOAD/COUNT/DONE FSM driving the loop_mux select.
// Optional auto-reload (reload on terminal count, wrap counter) under LOOP_AUTO_RELOAD_EN.
module loop_count_ctrl
    import loop_pkg::*;
#(
    parameter int WIDTH = LOOP_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    loop_count_ctrl_if.slave bus
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             sel_r;
    logic             busy_r;
    logic             done_r;
    logic             done_nxt_s;
`ifdef LOOP_AUTO_RELOAD_EN
    logic [7:0]       wrap_r;
    logic [7:0]       wrap_nxt_s;
`endif

    // Next-state, next-count and done-pulse decode; abort overrides every state.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        done_nxt_s  = 1'b0;
`ifdef LOOP_AUTO_RELOAD_EN
        wrap_nxt_s  = wrap_r;
`endif
        if (bus.abort) begin
            state_nxt_s = S_IDLE;
            count_nxt_s = {WIDTH{1'b0}};
`ifdef LOOP_AUTO_RELOAD_EN
            wrap_nxt_s  = 8'd0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        state_nxt_s = S_LOAD;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_LOAD: begin
                    count_nxt_s = bus.L;
                    state_nxt_s = S_COUNT;
                end
                S_COUNT: begin
                    if (!bus.tick_en) begin
                        count_nxt_s = count_r;
                    end else if (count_r != {WIDTH{1'b0}}) begin
                        // With sel=0 the mux returns current_count, so L-1 is the decrement.
                        count_nxt_s = bus.L - {{(WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        done_nxt_s = 1'b1;
`ifdef LOOP_AUTO_RELOAD_EN
                        if (bus.stop) begin
                            state_nxt_s = S_DONE;
                        end else begin
                            state_nxt_s = S_LOAD;
                            wrap_nxt_s  = wrap_r + 8'd1;
                        end
`else
                        state_nxt_s = S_DONE;
`endif
                    end
                end
                S_DONE: begin
                    state_nxt_s = S_IDLE;
                end
                default: begin
                    state_nxt_s = S_IDLE;
                    count_nxt_s = {WIDTH{1'b0}};
                end
            endcase
        end
    end

    // State, count and output registers; outputs are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            count_r <= {WIDTH{1'b0}};
            sel_r   <= SEL_INIT;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef LOOP_AUTO_RELOAD_EN
            wrap_r  <= 8'd0;
`endif
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            sel_r   <= sel_of(state_nxt_s);
            busy_r  <= busy_of(state_nxt_s);
            done_r  <= done_nxt_s;
`ifdef LOOP_AUTO_RELOAD_EN
            wrap_r  <= wrap_nxt_s;
`endif
        end
    end

    assign bus.sel           = sel_r;
    assign bus.current_count = count_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
`ifdef LOOP_AUTO_RELOAD_EN
    assign bus.wrap_cnt      = wrap_r;
`endif

endmodule

// File: tb/tb_loop_count_ctrl.sv
// Scoreboard bench for loop_count_ctrl with a behavioural stand-in for loop_mux.
// Busy/done cycles are checked against a queue of hand-derived expected snapshots.
module tb_loop_count_ctrl;
    import loop_pkg::*;

    typedef struct packed {
        logic       sel;
        logic       busy;
        logic       done;
        logic [9:0] cnt;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] initial_count;
    snap_t      exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    loop_count_ctrl_if #(.WIDTH(LOOP_WIDTH)) bus ();

    // loop_mux stand-in
    assign bus.L = bus.sel ? initial_count : bus.current_count;

    loop_count_ctrl #(.WIDTH(LOOP_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Monitor: every busy or done cycle must match the next queued snapshot.
    always @(negedge clk) begin
        snap_t got;
        snap_t e;
        got = '{sel: bus.sel, busy: bus.busy, done: bus.done, cnt: bus.current_count};
        if (got.busy || got.done) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output got sel=%0b busy=%0b done=%0b cnt=%0d, required no activity",
                         got.sel, got.busy, got.done, got.cnt);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL scoreboard got sel=%0b busy=%0b done=%0b cnt=%0d, required sel=%0b busy=%0b done=%0b cnt=%0d",
                             got.sel, got.busy, got.done, got.cnt, e.sel, e.busy, e.done, e.cnt);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic s, input logic b, input logic d, input logic [9:0] c);
        exp_q.push_back('{sel: s, busy: b, done: d, cnt: c});
    endtask

    // LOAD, then n..0 in COUNT with every tick enabled, then DONE.
    task automatic push_loop(input int n);
        push(1'b1, 1'b1, 1'b0, 10'd0);
        for (int i = n; i >= 0; i--) push(1'b0, 1'b1, 1'b0, 10'(i));
        push(1'b0, 1'b0, 1'b1, 10'd0);
    endtask

    task automatic chk(input string name, input logic s, input logic b, input logic d, input logic [9:0] c);
        n_vec++;
        if (bus.sel !== s || bus.busy !== b || bus.done !== d || bus.current_count !== c) begin
            n_err++;
            $display("FAIL %s got sel=%0b busy=%0b done=%0b cnt=%0d, required sel=%0b busy=%0b done=%0b cnt=%0d",
                     name, bus.sel, bus.busy, bus.done, bus.current_count, s, b, d, c);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.tick_en   = 1'b0;
        initial_count = 10'd0;
`ifdef LOOP_AUTO_RELOAD_EN
        bus.stop      = 1'b1;
`endif
        repeat (2) step();
        chk("reset", 1'b1, 1'b0, 1'b0, 10'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_hold", 1'b1, 1'b0, 1'b0, 10'd0);
        end

        // Basic loop N=3
        initial_count = 10'd3;
        bus.tick_en   = 1'b1;
        push_loop(3);
        pulse_start();
        repeat (6) step();
        chk("basic_idle", 1'b1, 1'b0, 1'b0, 10'd0);

        // Gated ticks N=2, pattern 1,0,1,0,1 in COUNT
        initial_count = 10'd2;
        push(1'b1, 1'b1, 1'b0, 10'd0);
        push(1'b0, 1'b1, 1'b0, 10'd2);
        push(1'b0, 1'b1, 1'b0, 10'd1);
        push(1'b0, 1'b1, 1'b0, 10'd1);
        push(1'b0, 1'b1, 1'b0, 10'd0);
        push(1'b0, 1'b1, 1'b0, 10'd0);
        push(1'b0, 1'b0, 1'b1, 10'd0);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            step();
            bus.tick_en = (i % 2 == 0);
        end
        repeat (2) step();
        bus.tick_en = 1'b1;
        chk("gated_idle", 1'b1, 1'b0, 1'b0, 10'd0);

        // Zero count
        initial_count = 10'd0;
        push_loop(0);
        pulse_start();
        repeat (3) step();
        chk("zero_idle", 1'b1, 1'b0, 1'b0, 10'd0);

        // Maximum count
        initial_count = 10'd1023;
        push_loop(1023);
        pulse_start();
        repeat (1026) step();
        chk("max_idle", 1'b1, 1'b0, 1'b0, 10'd0);

        // start while busy is ignored
        initial_count = 10'd2;
        push_loop(2);
        pulse_start();
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        chk("start_busy_idle", 1'b1, 1'b0, 1'b0, 10'd0);
        repeat (2) step();

        // Abort at count 5
        initial_count = 10'd9;
        push(1'b1, 1'b1, 1'b0, 10'd0);
        for (int i = 9; i >= 5; i--) push(1'b0, 1'b1, 1'b0, 10'(i));
        pulse_start();
        repeat (5) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_idle", 1'b1, 1'b0, 1'b0, 10'd0);
        repeat (3) step();

        // abort with start in IDLE
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("abort_start_idle", 1'b1, 1'b0, 1'b0, 10'd0);
        repeat (2) step();

        // Async reset mid-COUNT at count 7
        initial_count = 10'd9;
        push(1'b1, 1'b1, 1'b0, 10'd0);
        for (int i = 9; i >= 7; i--) push(1'b0, 1'b1, 1'b0, 10'(i));
        pulse_start();
        repeat (3) step();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk("async_reset", 1'b1, 1'b0, 1'b0, 10'd0);
        #1 rst_n = 1'b1;
        step();
        chk("post_reset_idle", 1'b1, 1'b0, 1'b0, 10'd0);

`ifdef LOOP_AUTO_RELOAD_EN
        // Auto reload N=2: one reload, then stop
        initial_count = 10'd2;
        bus.stop      = 1'b0;
        push(1'b1, 1'b1, 1'b0, 10'd0);
        for (int i = 2; i >= 0; i--) push(1'b0, 1'b1, 1'b0, 10'(i));
        push(1'b1, 1'b1, 1'b1, 10'd0);
        for (int i = 2; i >= 0; i--) push(1'b0, 1'b1, 1'b0, 10'(i));
        push(1'b0, 1'b0, 1'b1, 10'd0);
        pulse_start();
        repeat (4) step();
        bus.stop = 1'b1;
        repeat (5) step();
        n_vec++;
        if (bus.wrap_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL wrap_one got %0d, required 1", bus.wrap_cnt);
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        n_vec++;
        if (bus.wrap_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL wrap_abort got %0d, required 0", bus.wrap_cnt);
        end
`endif

        step();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected got %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
